// File: rtl/dispatch_register_file_mp_if.sv
// Port bundle of the dispatch-stage register file: write ports, read ports,
// debug read and conflict status. The register file uses the slave modport.
interface dispatch_register_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = 16
);
  logic                         iRESET_SYNC;
  logic                         iWR0_VALID;
  logic [ADDR_W-1:0]            iWR0_ADDR;
  logic [DATA_W-1:0]            iWR0_DATA;
  logic                         iWR1_VALID;
  logic [ADDR_W-1:0]            iWR1_ADDR;
  logic [DATA_W-1:0]            iWR1_DATA;
  logic [RD_PORTS*ADDR_W-1:0]   iRD_ADDR;
  logic [RD_PORTS*DATA_W-1:0]   oRD_DATA;
  logic [ADDR_W-1:0]            iDBG_ADDR;
  logic [DATA_W-1:0]            oDBG_DATA;
  logic                         oWR_CONFLICT;
  logic [CNT_W-1:0]             oCONFLICT_CNT;

  modport master (
    output iRESET_SYNC,
    output iWR0_VALID, iWR0_ADDR, iWR0_DATA,
    output iWR1_VALID, iWR1_ADDR, iWR1_DATA,
    output iRD_ADDR,
    input  oRD_DATA,
    output iDBG_ADDR,
    input  oDBG_DATA,
    input  oWR_CONFLICT,
    input  oCONFLICT_CNT
  );

  modport slave (
    input  iRESET_SYNC,
    input  iWR0_VALID, iWR0_ADDR, iWR0_DATA,
    input  iWR1_VALID, iWR1_ADDR, iWR1_DATA,
    input  iRD_ADDR,
    output oRD_DATA,
    input  iDBG_ADDR,
    output oDBG_DATA,
    output oWR_CONFLICT,
    output oCONFLICT_CNT
  );
endinterface

// File: rtl/dispatch_register_file_mp.sv
// Multi-port dispatch register file: two prioritised write ports, N bypassed
// read ports, per-entry valid bits (reset-free data array), debug read, conflict stats.
module dispatch_register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  dispatch_register_file_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          r_mem [DEPTH];
  logic [DEPTH-1:0]           r_valid;
  logic                       r_conflict;
  logic [CNT_W-1:0]           r_cnt;
  logic [DATA_W-1:0]          r_dbg;

  logic                       w_same_addr;
  logic                       w_conflict;
  logic                       w_wr0_en;
  logic                       w_wr1_en;
  logic [DEPTH-1:0]           w_valid_set;
  logic [DATA_W-1:0]          w_dbg_data;
  logic                       w_cnt_sat;
  logic [RD_PORTS*DATA_W-1:0] w_rd_data;

  // Port 0 is suppressed on a same-address collision so port 1 alone lands.
  always_comb begin
    w_same_addr = (bus.iWR0_ADDR == bus.iWR1_ADDR);
    w_conflict  = bus.iWR0_VALID & bus.iWR1_VALID & w_same_addr & ~bus.iRESET_SYNC;
    w_wr1_en    = bus.iWR1_VALID & ~bus.iRESET_SYNC;
    w_wr0_en    = bus.iWR0_VALID & ~bus.iRESET_SYNC & ~(bus.iWR1_VALID & w_same_addr);
    w_valid_set = (w_wr0_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << bus.iWR0_ADDR) : {DEPTH{1'b0}})
                | (w_wr1_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << bus.iWR1_ADDR) : {DEPTH{1'b0}});
    w_cnt_sat   = (r_cnt == {CNT_W{1'b1}});
  end

  // Debug view of the stored state, never the in-flight write data.
  always_comb begin
    if (r_valid[bus.iDBG_ADDR]) begin
      w_dbg_data = r_mem[bus.iDBG_ADDR];
    end else begin
      w_dbg_data = {DATA_W{1'b0}};
    end
  end

  // Valid vector: the only reset state the storage needs.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_valid <= {DEPTH{1'b0}};
    end else if (bus.iRESET_SYNC) begin
      r_valid <= {DEPTH{1'b0}};
    end else begin
      r_valid <= r_valid | w_valid_set;
    end
  end

  // Data array, deliberately without reset so it can map onto RAM.
  always_ff @(posedge iCLOCK) begin
    if (w_wr0_en) begin
      r_mem[bus.iWR0_ADDR] <= bus.iWR0_DATA;
    end
    if (w_wr1_en) begin
      r_mem[bus.iWR1_ADDR] <= bus.iWR1_DATA;
    end
  end

  // Conflict pulse, saturating conflict counter and debug register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_conflict <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
      r_dbg      <= {DATA_W{1'b0}};
    end else if (bus.iRESET_SYNC) begin
      r_conflict <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
      r_dbg      <= {DATA_W{1'b0}};
    end else begin
      r_conflict <= w_conflict;
      r_dbg      <= w_dbg_data;
      if (w_conflict && !w_cnt_sat) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = bus.iRD_ADDR[g*ADDR_W +: ADDR_W];

    // Read mux: clear, then port 1 bypass, then port 0 bypass, then array.
    always_comb begin
      if (bus.iRESET_SYNC) begin
        w_data = {DATA_W{1'b0}};
      end else if (bus.iWR1_VALID && (bus.iWR1_ADDR == w_addr)) begin
        w_data = bus.iWR1_DATA;
      end else if (bus.iWR0_VALID && (bus.iWR0_ADDR == w_addr)) begin
        w_data = bus.iWR0_DATA;
      end else if (r_valid[w_addr]) begin
        w_data = r_mem[w_addr];
      end else begin
        w_data = {DATA_W{1'b0}};
      end
    end

    assign w_rd_data[g*DATA_W +: DATA_W] = w_data;
  end

  assign bus.oRD_DATA      = w_rd_data;
  assign bus.oDBG_DATA     = r_dbg;
  assign bus.oWR_CONFLICT  = r_conflict;
  assign bus.oCONFLICT_CNT = r_cnt;

endmodule

// File: tb/tb_dispatch_register_file_mp.sv
// Directed plus randomised bench for dispatch_register_file_mp: a default
// instance and a wide 4-read-port instance, both checked through a scoreboard queue.
module tb_dispatch_register_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dispatch_register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .CNT_W(16)) bus_a ();
  dispatch_register_file_mp_if #(.DATA_W(64), .ADDR_W(6), .RD_PORTS(4), .CNT_W(2))  bus_b ();

  dispatch_register_file_mp #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .CNT_W(16)) dut_a (
    .iCLOCK(clk), .inRESET(rst_n), .bus(bus_a));
  dispatch_register_file_mp #(.DATA_W(64), .ADDR_W(6), .RD_PORTS(4), .CNT_W(2)) dut_b (
    .iCLOCK(clk), .inRESET(rst_n), .bus(bus_b));

  typedef struct { string tag; logic [63:0] val; } exp_t;
  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // reference model of the wide instance
  logic [63:0] mb [64];
  bit          vb [64];
  int          cntb = 0;

  task automatic push(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic push32(input string tag, input logic [31:0] v);
    push(tag, {32'd0, v});
  endtask

  task automatic pop(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [63:0] rd_a(input int k);
    return {32'd0, bus_a.oRD_DATA[k*32 +: 32]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    bus_a.iRESET_SYNC = 1'b0;
    bus_a.iWR0_VALID  = 1'b0;
    bus_a.iWR1_VALID  = 1'b0;
  endtask

  task automatic a_wr(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bus_a.iWR0_VALID = v0; bus_a.iWR0_ADDR = a0; bus_a.iWR0_DATA = d0;
    bus_a.iWR1_VALID = v1; bus_a.iWR1_ADDR = a1; bus_a.iWR1_DATA = d1;
  endtask

  task automatic a_rd(input logic [4:0] r0, input logic [4:0] r1);
    bus_a.iRD_ADDR = {r1, r0};
  endtask

  task automatic a_stat(input string tag, input logic conf, input logic [15:0] cnt);
    push({tag, "_conf"}, {63'd0, conf});
    push({tag, "_cnt"},  {48'd0, cnt});
  endtask

  task automatic a_pop_stat();
    pop({63'd0, bus_a.oWR_CONFLICT});
    pop({48'd0, bus_a.oCONFLICT_CNT});
  endtask

  // One cycle on the wide instance: drive, check reads, step model, check registered outputs.
  task automatic b_step(input bit clr, input bit v0, input logic [5:0] a0, input logic [63:0] d0,
                        input bit v1, input logic [5:0] a1, input logic [63:0] d1,
                        input logic [23:0] ra, input logic [5:0] da);
    logic [5:0]  addr;
    logic [63:0] exp_v;
    logic [63:0] dbg_e;
    bit          conf;
    bus_b.iRESET_SYNC = clr;
    bus_b.iWR0_VALID = v0; bus_b.iWR0_ADDR = a0; bus_b.iWR0_DATA = d0;
    bus_b.iWR1_VALID = v1; bus_b.iWR1_ADDR = a1; bus_b.iWR1_DATA = d1;
    bus_b.iRD_ADDR = ra;
    bus_b.iDBG_ADDR = da;
    for (int k = 0; k < 4; k++) begin
      addr = ra[k*6 +: 6];
      if (clr)                      exp_v = 64'd0;
      else if (v1 && (a1 == addr))  exp_v = d1;
      else if (v0 && (a0 == addr))  exp_v = d0;
      else if (vb[addr])            exp_v = mb[addr];
      else                          exp_v = 64'd0;
      push($sformatf("b_rd%0d_addr%0d", k, addr), exp_v);
    end
    #1;
    for (int k = 0; k < 4; k++) pop(bus_b.oRD_DATA[k*64 +: 64]);
    conf  = v0 && v1 && (a0 == a1) && !clr;
    dbg_e = vb[da] ? mb[da] : 64'd0;
    if (clr) begin
      for (int i = 0; i < 64; i++) vb[i] = 1'b0;
      cntb  = 0;
      dbg_e = 64'd0;
    end else begin
      if (v0) begin mb[a0] = d0; vb[a0] = 1'b1; end
      if (v1) begin mb[a1] = d1; vb[a1] = 1'b1; end
      if (conf && cntb < 3) cntb++;
    end
    push("b_conf", {63'd0, conf});
    push("b_cnt", 64'(cntb));
    push("b_dbg", dbg_e);
    tick();
    pop({63'd0, bus_b.oWR_CONFLICT});
    pop({62'd0, bus_b.oCONFLICT_CNT});
    pop(bus_b.oDBG_DATA);
  endtask

  initial begin
    logic [23:0] ra;
    rst_n = 1'b0;
    a_idle();
    a_wr(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    a_rd(5'd0, 5'd0);
    bus_a.iDBG_ADDR = 5'd0;
    bus_b.iRESET_SYNC = 1'b0;
    bus_b.iWR0_VALID = 1'b0; bus_b.iWR0_ADDR = 6'd0; bus_b.iWR0_DATA = 64'd0;
    bus_b.iWR1_VALID = 1'b0; bus_b.iWR1_ADDR = 6'd0; bus_b.iWR1_DATA = 64'd0;
    bus_b.iRD_ADDR = 24'd0;
    bus_b.iDBG_ADDR = 6'd0;
    for (int i = 0; i < 64; i++) begin mb[i] = 64'd0; vb[i] = 1'b0; end
    #2;

    // reset: every address reads zero, status cleared
    for (int a = 0; a < 32; a++) begin
      a_rd(5'(a), 5'(31 - a));
      push32("rst_rd0", 32'd0);
      push32("rst_rd1", 32'd0);
      #1;
      pop(rd_a(0));
      pop(rd_a(1));
    end
    a_stat("rst", 1'b0, 16'd0);
    a_pop_stat();
    push32("rst_dbg", 32'd0);
    pop({32'd0, bus_a.oDBG_DATA});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write addr 3, bypass then array, debug lags by one edge
    a_wr(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    a_rd(5'd3, 5'd4);
    bus_a.iDBG_ADDR = 5'd3;
    push32("wr_bypass_rd0", 32'hDEADBEEF);
    push32("wr_unwritten_rd1", 32'd0);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    push32("wr_dbg_prewrite", 32'd0);
    tick();
    a_idle();
    pop({32'd0, bus_a.oDBG_DATA});
    push32("wr_array_rd0", 32'hDEADBEEF);
    #1;
    pop(rd_a(0));
    push32("wr_dbg_after", 32'hDEADBEEF);
    tick();
    pop({32'd0, bus_a.oDBG_DATA});

    // same-address conflict: port 1 wins, one-cycle pulse, count 1
    a_wr(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
    a_rd(5'd7, 5'd7);
    push32("conf_byp_rd0", 32'h22222222);
    push32("conf_byp_rd1", 32'h22222222);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    a_stat("conf_pulse", 1'b1, 16'd1);
    tick();
    a_idle();
    a_pop_stat();
    push32("conf_array_rd0", 32'h22222222);
    #1;
    pop(rd_a(0));
    a_stat("conf_end", 1'b0, 16'd1);
    tick();
    a_pop_stat();

    // independent writes to different addresses
    a_wr(1'b1, 5'd1, 32'h0000000A, 1'b1, 5'd2, 32'h0000000B);
    a_rd(5'd1, 5'd2);
    push32("ind_byp_rd0", 32'h0000000A);
    push32("ind_byp_rd1", 32'h0000000B);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    a_stat("ind", 1'b0, 16'd1);
    tick();
    a_idle();
    a_pop_stat();
    push32("ind_arr_rd0", 32'h0000000A);
    push32("ind_arr_rd1", 32'h0000000B);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));

    // fill every entry, spot-check, then sync clear racing a conflicting write
    for (int i = 0; i < 16; i++) begin
      a_wr(1'b1, 5'(2*i), 32'hC0DE0000 + 32'(2*i), 1'b1, 5'(2*i+1), 32'hC0DE0000 + 32'(2*i+1));
      tick();
    end
    a_idle();
    a_rd(5'd7, 5'd31);
    push32("fill_rd0", 32'hC0DE0007);
    push32("fill_rd1", 32'hC0DE001F);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    bus_a.iRESET_SYNC = 1'b1;
    a_wr(1'b1, 5'd5, 32'h00000055, 1'b1, 5'd5, 32'h00000066);
    a_rd(5'd5, 5'd9);
    push32("clr_same_cycle_rd0", 32'd0);
    push32("clr_same_cycle_rd1", 32'd0);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    a_stat("clr", 1'b0, 16'd0);
    push32("clr_dbg", 32'd0);
    tick();
    a_idle();
    a_pop_stat();
    pop({32'd0, bus_a.oDBG_DATA});
    for (int a = 0; a < 32; a++) begin
      a_rd(5'(a), 5'(31 - a));
      push32($sformatf("clr_after_rd0_%0d", a), 32'd0);
      push32($sformatf("clr_after_rd1_%0d", 31 - a), 32'd0);
      #1;
      pop(rd_a(0));
      pop(rd_a(1));
    end

    // write after clear is accepted again
    a_wr(1'b1, 5'd5, 32'h00000077, 1'b0, 5'd0, 32'd0);
    bus_a.iDBG_ADDR = 5'd5;
    tick();
    a_idle();
    a_rd(5'd5, 5'd6);
    push32("postclr_rd0", 32'h00000077);
    push32("postclr_rd1", 32'd0);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    push32("postclr_dbg", 32'h00000077);
    tick();
    pop({32'd0, bus_a.oDBG_DATA});

    // async reset mid-stream, then the first edge is a normal write
    a_wr(1'b1, 5'd9, 32'h00000001, 1'b1, 5'd9, 32'h00000002);
    tick();
    a_idle();
    a_stat("pre_arst", 1'b1, 16'd1);
    a_pop_stat();
    #1;
    rst_n = 1'b0;
    #1;
    a_rd(5'd5, 5'd9);
    push32("arst_rd0", 32'd0);
    push32("arst_rd1", 32'd0);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));
    a_stat("arst", 1'b0, 16'd0);
    a_pop_stat();
    for (int i = 0; i < 64; i++) vb[i] = 1'b0;
    cntb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    a_wr(1'b1, 5'd10, 32'h000000AB, 1'b0, 5'd0, 32'd0);
    tick();
    a_idle();
    a_rd(5'd10, 5'd5);
    push32("arst_first_edge_rd0", 32'h000000AB);
    push32("arst_first_edge_rd1", 32'd0);
    #1;
    pop(rd_a(0));
    pop(rd_a(1));

    // wide instance: random traffic against the model
    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < 4; k++) ra[k*6 +: 6] = 6'($urandom_range(0, 15));
      b_step($urandom_range(0, 31) == 0,
             1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), {$urandom, $urandom},
             ra, 6'($urandom_range(0, 15)));
    end

    // wide instance: clear, then five conflicts saturate the 2-bit counter
    b_step(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 24'd0, 6'd0);
    for (int n = 0; n < 5; n++) begin
      b_step(1'b0, 1'b1, 6'(40 + n), 64'h1111_0000_0000_0000 + 64'(n),
             1'b1, 6'(40 + n), 64'h2222_0000_0000_0000 + 64'(n),
             {6'd63, 6'(40 + n), 6'(40 + n), 6'd41}, 6'(40 + n));
    end
    push("b_cnt_saturated", 64'd3);
    pop({62'd0, bus_b.oCONFLICT_CNT});
    b_step(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, {6'd40, 6'd42, 6'd44, 6'd63}, 6'd44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
